mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32IM core.
- Consumes the EX/MEM pipeline register outputs (ALU result, load/store class, store data, rd, wb_en) and drives the data-memory request/response port.
- Formats load data and registers the MEM/WB pipeline.
- Raises `mem_stall` so that IF..EX/MEM hold while a memory transaction is outstanding.

Parameters:
- ADDR_W, 32, data-memory byte-address width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `rd_addr_mem`  in  5  destination register from EX/MEM.
- `wb_en_mem`  in  1  writeback enable from EX/MEM.
- `is_load_mem`  in  3  load class:
  - 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU.
  - 110 and 111 are treated as none.
- `is_store_mem`  in  1  store valid.
- `st_size_mem`  in  2  store width: 00 SB, 01 SH, 10 SW; 11 is treated as SW.
- `alu_out_mem`  in  32  effective address, or ALU/MUL/PC+4 result.
- `st_data_mem`  in  32  forwarded rs2 store data.
- `dm_req`  out  1  memory request (combinational).
- `dm_we`  out  1  write request.
- `dm_addr`  out  ADDR_W  word-aligned address: `{alu_out_mem[ADDR_W-1:2], 2'b00}`.
- `dm_wstrb`  out  4  byte write strobes.
- `dm_wdata`  out  32  lane-shifted store data.
- `dm_gnt`  in  1  request accepted this cycle.
- `dm_rvalid`  in  1  read data valid.
- `dm_rdata`  in  32  read word.
- `mem_stall`  out  1  hold upstream stages.
- `fw_from_mem`  out  32  forwarding value = `alu_out_mem`.
- `rd_addr_wb`  out  5  MEM/WB rd.
- `wb_en_wb`  out  1  MEM/WB writeback enable.
- `wb_data_wb`  out  32  MEM/WB writeback data.

Behaviour:
- FSM states: IDLE, WAIT_R.
  - Reset → IDLE.
  - Outputs after reset: `rd_addr_wb`=0, `wb_en_wb`=0, `wb_data_wb`=0.
  - While `rst` is high, `dm_req`=0 and `mem_stall`=0.
- Memory op (`mem_op`) = `is_store_mem` OR a valid `is_load_mem` code.
  - If both store and load are set, store wins.
- IDLE:
  - `dm_req` = `mem_op`; `dm_we` = `is_store_mem`.
  - Store, `dm_gnt`=1: store completes; `mem_stall`=0; MEM/WB captures `wb_en_mem`/`rd_addr_mem`/`alu_out_mem` at the edge.
  - Load, `dm_gnt`=1: go to WAIT_R; `mem_stall`=1.
  - `mem_op`, `dm_gnt`=0: stay in IDLE; `mem_stall`=1. Upstream holds its inputs, so `dm_req`/addr/data stay stable until granted.
  - No `mem_op`: `mem_stall`=0; MEM/WB captures `wb_data_wb`=`alu_out_mem` at the edge.
- WAIT_R:
  - `dm_req`=0.
  - `dm_rvalid`=0: `mem_stall`=1.
  - `dm_rvalid`=1: `mem_stall`=0; `wb_data_wb` ← formatted `dm_rdata`; `wb_en_wb` ← `wb_en_mem`; → IDLE.
  - Minimum load latency: grant cycle + 1 response cycle.
  - A response in the same cycle as the grant is not supported.
- Stall bubble: every stalled cycle (`mem_stall`=1) loads MEM/WB with `wb_en_wb`=0. `rd_addr_wb` and `wb_data_wb` hold.
- `dm_rvalid` in IDLE is ignored; this covers stale responses after a reset mid-transaction.
- Store lanes (`off` = `alu_out_mem[1:0]`):
  - SB: `wstrb` = 0001<<`off`; `wdata` = {4{byte}}.
  - SH: `wstrb` = 0011<<(`off[1]`*2); `wdata` = {2{half}}.
  - SW: `wstrb` = 1111; `wdata` = `st_data_mem`.
- Load format:
  - Byte = `rdata[8*off +: 8]`; half = `rdata[16*off[1] +: 16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Loads always issue with `dm_we`=0 and `dm_wstrb`=0000.
- `wb_en_wb` is not qualified by `rd`=0; the register file ignores x0.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output `misalign_err` (1 bit, registered, reset 0).
  - Misaligned cases: LH/LHU/SH with `off[0]`=1, or LW/SW with `off`≠0.
  - On a misaligned op: `dm_req`=0, `mem_stall`=0; MEM/WB loads `wb_en_wb`=0; `misalign_err` pulses 1 for one cycle.
- Undefined:
  - No `misalign_err` port.
  - Halfword ignores `off[0]`; word ignores `off`. The access is issued normally.

Test Plan:
- SW addr 0x1000, data 0xDEADBEEF, `dm_gnt`=1 same cycle → `dm_req`=1, `dm_we`=1, `dm_addr`=0x1000, `wstrb`=1111; no stall; `wb_en_wb`=`wb_en_mem` next cycle.
- SB addr 0x1003, data 0x000000A5 → `wstrb`=1000, `wdata`=0xA5A5A5A5.
- LB addr 0x2001, `dm_rdata`=0x12348056: grant cycle 0, `rvalid` cycle 2 → `mem_stall`=1 cycles 0–1 with `wb_en_wb`=0 bubbles; `wb_data_wb`=0xFFFFFF80 after cycle 2. LBU in the same setup gives 0x00000080.
- LHU addr 0x2002, `rdata`=0x8001FFFF → 0x00008001. LH on the same access gives 0xFFFF8001.
- `dm_gnt` low 3 cycles on LW → `dm_req` stays high, addr stable, `mem_stall`=1 for 3 cycles plus the WAIT_R cycles.
- `rst` asserted in WAIT_R, then a stale `dm_rvalid` arrives → FSM in IDLE; MEM/WB outputs 0. With MEM_MISALIGN_TRAP_EN: LW addr 0x2002 → no `dm_req`, `misalign_err`=1 one cycle, `wb_en_wb`=0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage of the RV32IM pipeline: data-memory handshake, store lane steering,
// load formatting and the MEM/WB register. Optional misalignment trap: MEM_MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rd_addr_mem,
    input  logic              wb_en_mem,
    input  logic [2:0]        is_load_mem,
    input  logic              is_store_mem,
    input  logic [1:0]        st_size_mem,
    input  logic [31:0]       alu_out_mem,
    input  logic [31:0]       st_data_mem,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_wstrb,
    output logic [31:0]       dm_wdata,
    input  logic              dm_gnt,
    input  logic              dm_rvalid,
    input  logic [31:0]       dm_rdata,
    output logic              mem_stall,
    output logic [31:0]       fw_from_mem,
    output logic [4:0]        rd_addr_wb,
    output logic              wb_en_wb,
    output logic [31:0]       wb_data_wb
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              misalign_err
`endif
);

    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LH  = 3'b010;
    localparam logic [2:0] LD_LW  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    typedef enum logic {IDLE, WAIT_R} state_t;

    state_t      state_q, state_d;
    logic        load_vld, store_op, load_op, mem_op, misalign, issue;
    logic [1:0]  off;

    function automatic logic [31:0] fmt_load(input logic [2:0] cls, input logic [1:0] o,
                                             input logic [31:0] w);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        sh;
        sh = w >> {o, 3'b000};
        b  = sh[7:0];
        h  = o[1] ? w[31:16] : w[15:0];
        case (cls)
            LD_LB:   fmt_load = 32'(b);
            LD_LBU:  fmt_load = {24'd0, b};
            LD_LH:   fmt_load = 32'(h);
            LD_LHU:  fmt_load = {16'd0, h};
            default: fmt_load = w;
        endcase
    endfunction

    function automatic logic [3:0] st_strb(input logic [1:0] sz, input logic [1:0] o);
        case (sz)
            2'b00:   st_strb = 4'b0001 << o;
            2'b01:   st_strb = o[1] ? 4'b1100 : 4'b0011;
            default: st_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] st_lanes(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   st_lanes = {4{d[7:0]}};
            2'b01:   st_lanes = {2{d[15:0]}};
            default: st_lanes = d;
        endcase
    endfunction

    assign off      = alu_out_mem[1:0];
    assign load_vld = (is_load_mem != 3'b000) && (is_load_mem <= LD_LHU);
    assign store_op = is_store_mem;
    assign load_op  = load_vld && !is_store_mem;
    assign mem_op   = store_op || load_op;

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        if (store_op)
            misalign = (st_size_mem == 2'b01) ? off[0] :
                       (st_size_mem == 2'b00) ? 1'b0 : (off != 2'b00);
        else if (load_op)
            misalign = (is_load_mem == LD_LH || is_load_mem == LD_LHU) ? off[0] :
                       (is_load_mem == LD_LW) ? (off != 2'b00) : 1'b0;
    end
`else
    assign misalign = 1'b0;
`endif

    assign issue       = mem_op && !misalign;
    assign dm_addr     = {alu_out_mem[ADDR_W-1:2], 2'b00};
    assign dm_wdata    = st_lanes(st_size_mem, st_data_mem);
    assign dm_we       = dm_req && store_op;
    assign dm_wstrb    = dm_we ? st_strb(st_size_mem, off) : 4'b0000;
    assign fw_from_mem = alu_out_mem;

    always_comb begin
        state_d   = state_q;
        dm_req    = 1'b0;
        mem_stall = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    dm_req = issue;
                    if (issue) begin
                        if (store_op) begin
                            mem_stall = !dm_gnt;
                        end else begin
                            mem_stall = 1'b1;
                            if (dm_gnt) state_d = WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    mem_stall = !dm_rvalid;
                    if (dm_rvalid) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // MEM/WB boundary: stalled cycles insert bubbles, rd/data hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_wb <= 5'd0;
            wb_en_wb   <= 1'b0;
            wb_data_wb <= 32'd0;
        end else if (mem_stall) begin
            wb_en_wb   <= 1'b0;
        end else if (state_q == WAIT_R) begin
            rd_addr_wb <= rd_addr_mem;
            wb_en_wb   <= wb_en_mem;
            wb_data_wb <= fmt_load(is_load_mem, off, dm_rdata);
        end else begin
            rd_addr_wb <= rd_addr_mem;
            wb_en_wb   <= wb_en_mem && !(mem_op && misalign);
            wb_data_wb <= alu_out_mem;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) misalign_err <= 1'b0;
        else     misalign_err <= (state_q == IDLE) && mem_op && misalign;
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table-driven store/ALU vectors, scripted load and reset sequences,
// MEM/WB writebacks matched against a scoreboard queue.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr_mem;
    logic        wb_en_mem;
    logic [2:0]  is_load_mem;
    logic        is_store_mem;
    logic [1:0]  st_size_mem;
    logic [31:0] alu_out_mem;
    logic [31:0] st_data_mem;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_stall;
    logic [31:0] fw_from_mem;
    logic [4:0]  rd_addr_wb;
    logic        wb_en_wb;
    logic [31:0] wb_data_wb;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .rd_addr_mem(rd_addr_mem), .wb_en_mem(wb_en_mem),
        .is_load_mem(is_load_mem), .is_store_mem(is_store_mem),
        .st_size_mem(st_size_mem), .alu_out_mem(alu_out_mem), .st_data_mem(st_data_mem),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_stall(mem_stall), .fw_from_mem(fw_from_mem),
        .rd_addr_wb(rd_addr_wb), .wb_en_wb(wb_en_wb), .wb_data_wb(wb_data_wb)
`ifdef MEM_MISALIGN_TRAP_EN
        , .misalign_err(misalign_err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;
    wb_t sbq[$];

    // Every cycle with a writeback must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && wb_en_wb) begin
            if (sbq.size() == 0) begin
                check("wb_unexpected", 32'(wb_en_wb), 32'd0);
            end else begin
                wb_t e;
                e = sbq.pop_front();
                check("wb_rd", 32'(rd_addr_wb), 32'(e.rd));
                check("wb_data", wb_data_wb, e.data);
            end
        end
    end

    typedef struct {
        logic [2:0]  ld;
        logic        st;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] sd;
        logic        wb;
        logic        e_req;
        logic        e_we;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic        chk_wdata;
        logic        e_stall;
    } svec_t;
    svec_t sv[$];

    task automatic set_idle();
        is_load_mem = 3'b000; is_store_mem = 1'b0; st_size_mem = 2'b00;
        alu_out_mem = 32'd0; st_data_mem = 32'd0; wb_en_mem = 1'b0; rd_addr_mem = 5'd0;
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0BAD0BAD;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [2:0] cls, input logic [31:0] addr, input logic [31:0] rdata,
                           input int gdly, input int rdly, input logic [31:0] exp,
                           input logic [4:0] rd);
        step();
        set_idle();
        is_load_mem = cls; alu_out_mem = addr; wb_en_mem = 1'b1; rd_addr_mem = rd;
        sbq.push_back('{rd, exp});
        for (int i = 0; i < gdly; i++) begin
            @(negedge clk);
            check("ld_wait_req", 32'(dm_req), 32'd1);
            check("ld_wait_stall", 32'(mem_stall), 32'd1);
            check("ld_wait_addr", dm_addr, {addr[31:2], 2'b00});
            step();
        end
        dm_gnt = 1'b1;
        @(negedge clk);
        check("ld_gnt_req", 32'(dm_req), 32'd1);
        check("ld_gnt_we", 32'(dm_we), 32'd0);
        check("ld_gnt_strb", 32'(dm_wstrb), 32'd0);
        check("ld_gnt_stall", 32'(mem_stall), 32'd1);
        step();
        dm_gnt = 1'b0;
        for (int i = 0; i < rdly - 1; i++) begin
            @(negedge clk);
            check("ld_resp_req", 32'(dm_req), 32'd0);
            check("ld_resp_stall", 32'(mem_stall), 32'd1);
            check("ld_bubble", 32'(wb_en_wb), 32'd0);
            step();
        end
        dm_rvalid = 1'b1; dm_rdata = rdata;
        @(negedge clk);
        check("ld_rvalid_stall", 32'(mem_stall), 32'd0);
        check("ld_rvalid_bubble", 32'(wb_en_wb), 32'd0);
        step();
        set_idle();
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        is_store_mem = 1'b1; st_size_mem = 2'b10; alu_out_mem = 32'h1000; dm_gnt = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(dm_req), 32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        step();
        rst = 1'b0;
        set_idle();
        @(negedge clk);
        check("rst_rd_wb", 32'(rd_addr_wb), 32'd0);
        check("rst_wb_en", 32'(wb_en_wb), 32'd0);
        check("rst_wb_data", wb_data_wb, 32'd0);

        // {ld, st, sz, addr, sd, wb, req, we, strb, wdata, chk_wdata, stall}
        sv.push_back('{3'b000, 1'b1, 2'b10, 32'h1000, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 4'b1111, 32'hDEADBEEF, 1'b1, 1'b0});
        sv.push_back('{3'b000, 1'b1, 2'b00, 32'h1003, 32'h000000A5, 1'b1, 1'b1, 1'b1, 4'b1000, 32'hA5A5A5A5, 1'b1, 1'b0});
        sv.push_back('{3'b000, 1'b1, 2'b00, 32'h1000, 32'h12345678, 1'b0, 1'b1, 1'b1, 4'b0001, 32'h78787878, 1'b1, 1'b0});
        sv.push_back('{3'b000, 1'b1, 2'b01, 32'h1002, 32'h1234BEEF, 1'b1, 1'b1, 1'b1, 4'b1100, 32'hBEEFBEEF, 1'b1, 1'b0});
        sv.push_back('{3'b000, 1'b1, 2'b01, 32'h1000, 32'h00005A5A, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h5A5A5A5A, 1'b1, 1'b0});
        sv.push_back('{3'b000, 1'b1, 2'b11, 32'h1004, 32'h01020304, 1'b1, 1'b1, 1'b1, 4'b1111, 32'h01020304, 1'b1, 1'b0});
        sv.push_back('{3'b000, 1'b0, 2'b00, 32'h00000055, 32'h0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0});
        sv.push_back('{3'b110, 1'b0, 2'b00, 32'h00000123, 32'h0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0});
        sv.push_back('{3'b111, 1'b0, 2'b00, 32'h00000456, 32'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0});
        sv.push_back('{3'b011, 1'b1, 2'b10, 32'h2008, 32'hCAFEBABE, 1'b1, 1'b1, 1'b1, 4'b1111, 32'hCAFEBABE, 1'b1, 1'b0});
`ifndef MEM_MISALIGN_TRAP_EN
        sv.push_back('{3'b000, 1'b1, 2'b01, 32'h1001, 32'h0000ABCD, 1'b0, 1'b1, 1'b1, 4'b0011, 32'hABCDABCD, 1'b1, 1'b0});
        sv.push_back('{3'b000, 1'b1, 2'b10, 32'h1007, 32'h11223344, 1'b0, 1'b1, 1'b1, 4'b1111, 32'h11223344, 1'b1, 1'b0});
`endif
        foreach (sv[i]) begin
            step();
            set_idle();
            is_load_mem = sv[i].ld; is_store_mem = sv[i].st; st_size_mem = sv[i].sz;
            alu_out_mem = sv[i].addr; st_data_mem = sv[i].sd; wb_en_mem = sv[i].wb;
            rd_addr_mem = 5'(i + 1); dm_gnt = 1'b1;
            if (sv[i].wb) sbq.push_back('{5'(i + 1), sv[i].addr});
            @(negedge clk);
            check($sformatf("v%0d_req", i), 32'(dm_req), 32'(sv[i].e_req));
            check($sformatf("v%0d_we", i), 32'(dm_we), 32'(sv[i].e_we));
            check($sformatf("v%0d_addr", i), dm_addr, {sv[i].addr[31:2], 2'b00});
            check($sformatf("v%0d_strb", i), 32'(dm_wstrb), 32'(sv[i].e_strb));
            if (sv[i].chk_wdata) check($sformatf("v%0d_wdata", i), dm_wdata, sv[i].e_wdata);
            check($sformatf("v%0d_stall", i), 32'(mem_stall), 32'(sv[i].e_stall));
            check($sformatf("v%0d_fw", i), fw_from_mem, sv[i].addr);
        end
        step();
        set_idle();

        do_load(3'b001, 32'h2001, 32'h12348056, 0, 2, 32'hFFFFFF80, 5'd20);
        do_load(3'b100, 32'h2001, 32'h12348056, 0, 2, 32'h00000080, 5'd21);
        do_load(3'b101, 32'h2002, 32'h8001FFFF, 0, 1, 32'h00008001, 5'd22);
        do_load(3'b010, 32'h2002, 32'h8001FFFF, 0, 2, 32'hFFFF8001, 5'd23);
        do_load(3'b001, 32'h2003, 32'h7F000000, 0, 1, 32'h0000007F, 5'd24);
        do_load(3'b011, 32'h2004, 32'hCAFEF00D, 3, 2, 32'hCAFEF00D, 5'd25);
        step();

        // Reset while a load is waiting for its response, then a stale response.
        is_load_mem = 3'b011; alu_out_mem = 32'h3000; wb_en_mem = 1'b1; rd_addr_mem = 5'd7;
        dm_gnt = 1'b1;
        step();
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_req", 32'(dm_req), 32'd0);
        check("mid_rst_stall", 32'(mem_stall), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_stall", 32'(mem_stall), 32'd0);
        check("post_rst_rd_wb", 32'(rd_addr_wb), 32'd0);
        check("post_rst_wb_en", 32'(wb_en_wb), 32'd0);
        check("post_rst_wb_data", wb_data_wb, 32'd0);
        step();
        alu_out_mem = 32'h77; wb_en_mem = 1'b1; rd_addr_mem = 5'd9;
        dm_rvalid = 1'b1; dm_rdata = 32'hBADBAD00;
        sbq.push_back('{5'd9, 32'h77});
        @(negedge clk);
        check("stale_rvalid_stall", 32'(mem_stall), 32'd0);
        step();
        set_idle();

`ifdef MEM_MISALIGN_TRAP_EN
        step();
        is_load_mem = 3'b011; alu_out_mem = 32'h2002; wb_en_mem = 1'b1; rd_addr_mem = 5'd11;
        dm_gnt = 1'b1;
        @(negedge clk);
        check("mis_req", 32'(dm_req), 32'd0);
        check("mis_stall", 32'(mem_stall), 32'd0);
        step();
        set_idle();
        @(negedge clk);
        check("mis_err", 32'(misalign_err), 32'd1);
        check("mis_wb_en", 32'(wb_en_wb), 32'd0);
        step();
        @(negedge clk);
        check("mis_err_pulse", 32'(misalign_err), 32'd0);
`endif

        repeat (3) step();
        check("sb_drain", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
